// File: rtl/elevator_pkg.sv
// Shared encodings and width helpers for the parametrised elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned bits_for(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases.
module elev_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl_param.sv
// N-floor elevator controller: latches calls, serves them in SCAN order with
// per-floor travel time and a timed, extendable door dwell.
module elevator_ctrl_param
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_FLOORS-1:0]         call_req,
  output logic [N_FLOORS-1:0]         floor_onehot,
  output logic [$clog2(N_FLOORS)-1:0] floor_idx,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        moving_up,
  output logic                        moving_down,
  output logic                        door_open
);

  localparam int unsigned IW   = idx_bits(N_FLOORS);
  localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = bits_for(TMAX);

  localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_DOOR   = TW'(DOOR_CYCLES - 1);
  localparam logic [IW-1:0] TOP      = IW'(N_FLOORS - 1);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [IW-1:0]       floor_q, floor_d;
  logic [N_FLOORS-1:0] pend_q, pend_d;

  logic [N_FLOORS-1:0] req_all, above, below;
  logic [IW-1:0]       up_nxt, dn_nxt;
  logic                t_load, t_tick, t_zero;
  logic [TW-1:0]       t_val;

  elev_timer #(.W(TW)) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .tick_i     (t_tick),
    .zero_o     (t_zero)
  );

  // Same-cycle button presses count as requests so an idle car reacts at once.
  always_comb begin
    req_all = pend_q | call_req;
    above   = '0;
    below   = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(floor_q)) above[i] = req_all[i];
      if (i < int'(floor_q)) below[i] = req_all[i];
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    pend_d  = req_all;
    t_load  = 1'b0;
    t_tick  = 1'b0;
    t_val   = T_TRAVEL;
    up_nxt  = floor_q + IW'(1);
    dn_nxt  = floor_q - IW'(1);

    case (state_q)
      ST_IDLE: begin
        if (req_all[floor_q]) begin
          pend_d[floor_q] = 1'b0;
          state_d         = ST_DOOR;
          t_load          = 1'b1;
          t_val           = T_DOOR;
        end else if ((|above) && (dir_q == DIR_UP || !(|below))) begin
          state_d = ST_UP;
          dir_d   = DIR_UP;
          t_load  = 1'b1;
        end else if (|below) begin
          state_d = ST_DOWN;
          dir_d   = DIR_DOWN;
          t_load  = 1'b1;
        end
      end

      ST_UP: begin
        if (!t_zero) begin
          t_tick = 1'b1;
        end else if (floor_q == TOP) begin
          state_d = ST_IDLE;
        end else begin
          floor_d = up_nxt;
          t_load  = 1'b1;
          if (req_all[up_nxt]) begin
            pend_d[up_nxt] = 1'b0;
            state_d        = ST_DOOR;
            t_val          = T_DOOR;
          end
        end
      end

      ST_DOWN: begin
        if (!t_zero) begin
          t_tick = 1'b1;
        end else if (floor_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          floor_d = dn_nxt;
          t_load  = 1'b1;
          if (req_all[dn_nxt]) begin
            pend_d[dn_nxt] = 1'b0;
            state_d        = ST_DOOR;
            t_val          = T_DOOR;
          end
        end
      end

      ST_DOOR: begin
        // Calls for the floor the door is open at are absorbed and restart the dwell.
        pend_d[floor_q] = 1'b0;
        if (call_req[floor_q]) begin
          t_load = 1'b1;
          t_val  = T_DOOR;
        end else if (!t_zero) begin
          t_tick = 1'b1;
        end else if (dir_q == DIR_UP) begin
          if (|above) begin
            state_d = ST_UP;
            t_load  = 1'b1;
          end else if (|below) begin
            state_d = ST_DOWN;
            dir_d   = DIR_DOWN;
            t_load  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (|below) begin
            state_d = ST_DOWN;
            t_load  = 1'b1;
          end else if (|above) begin
            state_d = ST_UP;
            dir_d   = DIR_UP;
            t_load  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      floor_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
    end
  end

  assign floor_idx    = floor_q;
  assign floor_onehot = {{(N_FLOORS-1){1'b0}}, 1'b1} << floor_q;
  assign pending      = pend_q;
  assign moving_up    = (state_q == ST_UP);
  assign moving_down  = (state_q == ST_DOWN);
  assign door_open    = (state_q == ST_DOOR);

endmodule

// File: tb/tb_elevator_ctrl_param.sv
// Directed bench for elevator_ctrl_param with a queue of expected stops.
module tb_elevator_ctrl_param;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int DC = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] call_req = '0;
  logic [N-1:0] floor_onehot;
  logic [1:0]   floor_idx;
  logic [N-1:0] pending;
  logic         moving_up, moving_down, door_open;

  elevator_ctrl_param #(
    .N_FLOORS      (N),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .floor_onehot (floor_onehot),
    .floor_idx    (floor_idx),
    .pending      (pending),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .door_open    (door_open)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    int           floor;
    logic [N-1:0] pend;
    int           cyc;
  } stop_t;

  stop_t sbq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    viol  = 0;
  bit    down_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] one;
    @(posedge clk);
    #1;
    cyc++;
    one = 4'b0001;
    if ((moving_up && moving_down) || (door_open && (moving_up || moving_down)) ||
        (floor_onehot !== (one << floor_idx)))
      viol++;
    if (moving_down) down_seen = 1'b1;
  endtask

  task automatic push_stop(input int id, input int fl, input logic [N-1:0] p, input int at_cyc);
    stop_t s;
    s.id    = id;
    s.floor = fl;
    s.pend  = p;
    s.cyc   = at_cyc;
    sbq.push_back(s);
  endtask

  task automatic wait_stop();
    stop_t s;
    int    n;
    n = 0;
    s = sbq.pop_front();
    while (!door_open && n < 100) begin
      step();
      n++;
    end
    chk($sformatf("stop%0d_door", s.id), 32'(door_open), 32'd1);
    chk($sformatf("stop%0d_floor", s.id), 32'(floor_idx), 32'(s.floor));
    chk($sformatf("stop%0d_pending", s.id), 32'(pending), 32'(s.pend));
    chk($sformatf("stop%0d_cycle", s.id), 32'(cyc), 32'(s.cyc));
  endtask

  task automatic dwell(input string tag, input int exp);
    int n;
    n = 0;
    while (door_open && n < 50) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic pulse(input logic [N-1:0] v);
    call_req = v;
    step();
    call_req = '0;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    call_req = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int c0;

    // Reset state
    do_reset();
    chk("rst_onehot", 32'(floor_onehot), 32'h1);
    chk("rst_idx", 32'(floor_idx), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_flags", {29'd0, moving_up, moving_down, door_open}, 32'd0);

    // Call at the idle floor opens the door without latching
    c0 = cyc;
    push_stop(0, 0, 4'b0000, c0 + 1);
    pulse(4'b0001);
    wait_stop();
    dwell("stop0_dwell", DC);

    // Ground to top in one run
    do_reset();
    c0 = cyc;
    pulse(4'b1000);
    chk("s2_moving_up", 32'(moving_up), 32'd1);
    chk("s2_pending", 32'(pending), 32'h8);
    push_stop(1, 3, 4'b0000, c0 + 1 + 3 * TC);
    repeat (TC) step();
    chk("s2_floor1", 32'(floor_idx), 32'd1);
    repeat (TC) step();
    chk("s2_floor2", 32'(floor_idx), 32'd2);
    wait_stop();
    dwell("stop1_dwell", DC);
    chk("s2_idle_flags", {29'd0, moving_up, moving_down, door_open}, 32'd0);

    // Two calls above, served in order
    do_reset();
    c0 = cyc;
    push_stop(2, 1, 4'b0100, c0 + 1 + TC);
    push_stop(3, 2, 4'b0000, c0 + 1 + TC + DC + TC);
    pulse(4'b0110);
    chk("s3_pending", 32'(pending), 32'h6);
    wait_stop();
    dwell("stop2_dwell", DC);
    chk("s3_continue_up", 32'(moving_up), 32'd1);
    wait_stop();
    dwell("stop3_dwell", DC);

    // Call behind the car waits until the run ahead is finished
    do_reset();
    c0 = cyc;
    push_stop(4, 3, 4'b0001, c0 + 1 + 3 * TC);
    push_stop(5, 0, 4'b0000, c0 + 1 + 3 * TC + DC + 3 * TC);
    pulse(4'b1000);
    repeat (TC) step();
    chk("s4_at_floor1", 32'(floor_idx), 32'd1);
    down_seen = 1'b0;
    pulse(4'b0001);
    chk("s4_pending", 32'(pending), 32'h9);
    wait_stop();
    chk("s4_no_early_reverse", 32'(down_seen), 32'd0);
    dwell("stop4_dwell", DC);
    chk("s4_reverse", 32'(moving_down), 32'd1);
    wait_stop();
    dwell("stop5_dwell", DC);

    // Re-press during door dwell extends it
    do_reset();
    c0 = cyc;
    push_stop(6, 2, 4'b0000, c0 + 1 + 2 * TC);
    pulse(4'b0100);
    wait_stop();
    step();
    chk("s5_door_cycle2", 32'(door_open), 32'd1);
    pulse(4'b0100);
    chk("s5_pending_absorbed", 32'(pending), 32'd0);
    dwell("s5_extended_dwell", DC);

    // Reset in mid-travel drops everything
    do_reset();
    c0 = cyc;
    push_stop(7, 3, 4'b0000, c0 + 1 + 3 * TC);
    pulse(4'b1000);
    wait_stop();
    dwell("stop7_dwell", DC);
    pulse(4'b0011);
    chk("s6_moving_down", 32'(moving_down), 32'd1);
    chk("s6_pending", 32'(pending), 32'h3);
    repeat (2) step();
    chk("s6_still_floor3", 32'(floor_idx), 32'd3);
    rst = 1'b0;
    step();
    chk("s6_rst_idx", 32'(floor_idx), 32'd0);
    chk("s6_rst_onehot", 32'(floor_onehot), 32'h1);
    chk("s6_rst_pending", 32'(pending), 32'd0);
    chk("s6_rst_flags", {29'd0, moving_up, moving_down, door_open}, 32'd0);
    rst = 1'b1;
    repeat (6) step();
    chk("s6_stays_idle", {27'd0, floor_idx, moving_up, moving_down, door_open}, 32'd0);

    chk("invariants", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
